// File: rtl/seq_ctrl.sv
// seq_ctrl: button-driven sequence controller for the LED counter datapath.
//
// Conditions the raw centre button (two-flop synchronizer, counting
// debouncer, rising-edge press detect) and runs an IDLE/RUN/PAUSE state
// machine. A prescaler produces a one-cycle step strobe every TICK_DIV
// cycles while running. Entering RUN reseeds the datapath through a
// one-cycle load strobe. Each resume from PAUSE advances the mode.
//
// Parameters:
//   DB_CYCLES  consecutive differing samples needed to accept a button change
//   TICK_DIV   clock cycles per step strobe (>= 2)
//   NUM_MODES  number of sequence modes (1..4)
//
// Ports:
//   clk      in   system clock, rising edge
//   sw       in   synchronous active-high reset
//   btnC     in   raw asynchronous bouncing push button
//   step     out  one-cycle strobe: datapath advances one position
//   load     out  one-cycle strobe: datapath reloads the seed for mode
//   mode     out  current sequence select, 0..NUM_MODES-1
//   running  out  high while in RUN
module seq_ctrl #(
    parameter int DB_CYCLES = 4,
    parameter int TICK_DIV  = 8,
    parameter int NUM_MODES = 4
) (
    input  logic       clk,
    input  logic       sw,
    input  logic       btnC,
    output logic       step,
    output logic       load,
    output logic [1:0] mode,
    output logic       running
);

    localparam int DW = $clog2(DB_CYCLES) + 1;
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DB_MAX   = DW'(DB_CYCLES - 1);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [1:0]    MODE_MAX = 2'(NUM_MODES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    logic          sync1_r;
    logic          b_sync_r;
    logic          b_stable_r;
    logic          b_stable_d_r;
    logic          press_r;
    logic [DW-1:0] db_cnt_r;

    state_t        state_r;
    state_t        state_s;
    logic [1:0]    mode_r;
    logic [1:0]    mode_s;
    logic          load_r;
    logic          load_s;
    logic [TW-1:0] tick_r;
    logic [TW-1:0] tick_s;
    logic [1:0]    next_mode_s;

    // Button conditioning: synchronizer, counting debouncer and press detect.
    always_ff @(posedge clk) begin
        if (sw) begin
            sync1_r      <= 1'b0;
            b_sync_r     <= 1'b0;
            b_stable_r   <= 1'b0;
            b_stable_d_r <= 1'b0;
            press_r      <= 1'b0;
            db_cnt_r     <= '0;
        end else begin
            sync1_r  <= btnC;
            b_sync_r <= sync1_r;
            // Any agreeing sample restarts the count, so only an unbroken
            // run of DB_CYCLES differing samples flips the stable level.
            if (b_sync_r != b_stable_r) begin
                if (db_cnt_r == DB_MAX) begin
                    b_stable_r <= ~b_stable_r;
                    db_cnt_r   <= '0;
                end else begin
                    db_cnt_r   <= db_cnt_r + DW'(1);
                end
            end else begin
                db_cnt_r <= '0;
            end
            b_stable_d_r <= b_stable_r;
            press_r      <= b_stable_r & ~b_stable_d_r;
        end
    end

    // Mode to use on resume; a single-mode build stays at 0.
    always_comb begin
        next_mode_s = 2'd0;
        if (mode_r == MODE_MAX) begin
            next_mode_s = 2'd0;
        end else begin
            next_mode_s = mode_r + 2'd1;
        end
    end

    // Next-state, mode, load and prescaler logic.
    always_comb begin
        state_s = state_r;
        mode_s  = mode_r;
        load_s  = 1'b0;
        tick_s  = tick_r;
        case (state_r)
            IDLE: begin
                tick_s = '0;
                if (press_r) begin
                    state_s = RUN;
                    mode_s  = 2'd0;
                    load_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                // The wrap also applies when a press lands on the tick
                // cycle, so PAUSE is entered with tick at 0.
                if (tick_r == TICK_MAX) begin
                    tick_s = '0;
                end else begin
                    tick_s = tick_r + TW'(1);
                end
                if (press_r) begin
                    state_s = PAUSE;
                end else begin
                    state_s = RUN;
                end
            end
            PAUSE: begin
                if (press_r) begin
                    state_s = RUN;
                    mode_s  = next_mode_s;
                    load_s  = 1'b1;
                    tick_s  = '0;
                end else begin
                    state_s = PAUSE;
                    tick_s  = tick_r;
                end
            end
            default: begin
                state_s = IDLE;
                mode_s  = 2'd0;
                tick_s  = '0;
            end
        endcase
    end

    // FSM, mode, load and prescaler registers.
    always_ff @(posedge clk) begin
        if (sw) begin
            state_r <= IDLE;
            mode_r  <= 2'd0;
            load_r  <= 1'b0;
            tick_r  <= '0;
        end else begin
            state_r <= state_s;
            mode_r  <= mode_s;
            load_r  <= load_s;
            tick_r  <= tick_s;
        end
    end

    assign running = (state_r == RUN);
    assign step    = (state_r == RUN) && (tick_r == TICK_MAX);
    assign load    = load_r;
    assign mode    = mode_r;

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed bench for seq_ctrl. Expected load events (cycle, mode) are queued
// when a press is driven and popped when the DUT raises load; every step is
// checked against the cadence implied by the most recent load.
module tb_seq_ctrl;

    logic       clk = 1'b0;
    logic       sw;
    logic       btnC;
    logic       step;
    logic       load;
    logic [1:0] mode;
    logic       running;

    typedef struct {
        int         cyc;
        logic [1:0] mode;
    } exp_t;

    exp_t exp_q[$];
    int   cyc       = 0;
    int   tests     = 0;
    int   fails     = 0;
    int   step_seen = 0;
    int   last_load = -1000;
    bit   mon_en    = 1'b0;

    seq_ctrl #(
        .DB_CYCLES(4),
        .TICK_DIV (8),
        .NUM_MODES(4)
    ) dut (
        .clk    (clk),
        .sw     (sw),
        .btnC   (btnC),
        .step   (step),
        .load   (load),
        .mode   (mode),
        .running(running)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Count rising edges; outputs sampled with cyc == k reflect edge k.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        if (mon_en) begin
            chk("step_load_excl", 32'(step & load), 32'd0);
            if (load === 1'b1) begin
                chk("load_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("load_cycle", cyc, e.cyc);
                    chk("load_mode", 32'(mode), 32'(e.mode));
                end
                last_load = cyc;
            end
            if (step === 1'b1) begin
                step_seen++;
                chk("step_running", 32'(running), 32'd1);
                chk("step_phase", (cyc - last_load) % 8, 32'd7);
            end
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(negedge clk);
            #1;
            monitor();
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_step"}, 32'(step), 32'd0);
        chk({tag, "_load"}, 32'(load), 32'd0);
        chk({tag, "_running"}, 32'(running), 32'd0);
        chk({tag, "_mode"}, 32'(mode), 32'd0);
    endtask

    // Press the button for 10 cycles; the FSM reacts 7 edges after the
    // first sampling edge. Returns the cycle on which the reaction shows.
    task automatic press(input bit resume, input logic [1:0] exp_mode, output int l);
        int   c;
        exp_t e;
        c    = cyc;
        btnC = 1'b1;
        l    = c + 8;
        if (resume) begin
            e.cyc  = c + 8;
            e.mode = exp_mode;
            exp_q.push_back(e);
        end
        wait_until(c + 7);
        chk("press_before", 32'(running), resume ? 32'd0 : 32'd1);
        wait_until(c + 8);
        chk("press_running", 32'(running), 32'(resume));
        chk("press_mode", 32'(mode), 32'(exp_mode));
        chk("press_load", 32'(load), 32'(resume));
        wait_until(c + 10);
        btnC = 1'b0;
        if (resume) begin
            wait_until(c + 14);
            chk("first_step_early", 32'(step), 32'd0);
            wait_until(c + 15);
            chk("first_step", 32'(step), 32'd1);
        end
        wait_until(c + 22);
    endtask

    initial begin
        int         l;
        int         c;
        int         s0;
        logic [1:0] cur_mode;
        exp_t       e;

        sw   = 1'b1;
        btnC = 1'b0;

        // Reset.
        wait_until(1);
        check_idle("reset");
        sw     = 1'b0;
        mon_en = 1'b1;
        repeat (50) begin
            wait_until(cyc + 1);
            check_idle("idle");
        end

        // Start.
        press(1'b1, 2'd0, l);
        cur_mode = 2'd0;
        s0 = step_seen;
        wait_until(cyc + 80);
        chk("run_steps_80", step_seen - s0, 32'd10);

        // Glitch rejection: 3 high, 1 low, 3 high.
        btnC = 1'b1;
        wait_until(cyc + 3);
        btnC = 1'b0;
        wait_until(cyc + 1);
        btnC = 1'b1;
        wait_until(cyc + 3);
        btnC = 1'b0;
        s0 = step_seen;
        wait_until(cyc + 40);
        chk("glitch_running", 32'(running), 32'd1);
        chk("glitch_mode", 32'(mode), 32'd0);
        chk("glitch_steps_40", step_seen - s0, 32'd5);

        // Pause and mode cycling 1, 2, 3, 0.
        for (int k = 1; k <= 4; k++) begin
            press(1'b0, cur_mode, l);
            s0 = step_seen;
            wait_until(cyc + 100);
            chk("pause_no_step", step_seen - s0, 32'd0);
            chk("pause_running", 32'(running), 32'd0);
            cur_mode = 2'(k % 4);
            press(1'b1, cur_mode, l);
            wait_until(cyc + 10);
        end

        // Press lands on a tick cycle: first sampling edge at l+25 puts
        // press on the FSM input while the step at l+31 is showing.
        wait_until(l + 24);
        btnC = 1'b1;
        wait_until(l + 30);
        chk("coinc_pre_step", 32'(step), 32'd0);
        wait_until(l + 31);
        chk("coinc_step", 32'(step), 32'd1);
        chk("coinc_running", 32'(running), 32'd1);
        s0 = step_seen;
        wait_until(l + 32);
        chk("coinc_paused", 32'(running), 32'd0);
        chk("coinc_no_step", 32'(step), 32'd0);
        wait_until(l + 35);
        btnC = 1'b0;
        wait_until(cyc + 50);
        chk("coinc_quiet", step_seen - s0, 32'd0);
        chk("coinc_still_paused", 32'(running), 32'd0);

        // Back to RUN at mode 2.
        press(1'b1, 2'd1, l);
        press(1'b0, 2'd1, l);
        press(1'b1, 2'd2, l);
        chk("pre_reset_mode", 32'(mode), 32'd2);

        // Mid-run reset with the button held.
        c    = cyc;
        btnC = 1'b1;
        sw   = 1'b1;
        e.cyc  = c + 9;
        e.mode = 2'd0;
        exp_q.push_back(e);
        wait_until(c + 1);
        check_idle("midreset");
        sw = 1'b0;
        wait_until(c + 8);
        chk("rst_hold_before", 32'(running), 32'd0);
        wait_until(c + 9);
        chk("rst_hold_running", 32'(running), 32'd1);
        chk("rst_hold_mode", 32'(mode), 32'd0);
        chk("rst_hold_load", 32'(load), 32'd1);
        wait_until(c + 12);
        btnC = 1'b0;
        wait_until(c + 16);
        chk("rst_hold_step", 32'(step), 32'd1);
        wait_until(cyc + 20);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
